// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package calc_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Smallest digit count whose decimal range exceeds 2^bits.
  function automatic int unsigned min_digits(input int unsigned bits);
    longint unsigned limit;
    longint unsigned pow;
    int unsigned     d;
    limit = 64'd1 << bits;
    pow   = 64'd10;
    d     = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (pow <= limit) begin
        pow = pow * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= BCD_W'(5)) corrected = digit + BCD_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input and a neg output.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS-1:0]         value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]       blank
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                    neg
`endif
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);
  localparam int unsigned ACC_W = BCD_W * DIGITS;
`ifdef BIN2BCD_SIGNED_EN
  localparam int unsigned MAG_BITS = BITS - 1;
`else
  localparam int unsigned MAG_BITS = BITS;
`endif
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  if (DIGITS < min_digits(MAG_BITS)) begin : g_digits_too_small
    $error("bin2bcd_seq: DIGITS too small for BITS");
  end

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_fixed;
  logic [BITS-1:0]    operand;
  logic [BITS-1:0]    mag;
  logic [CNT_W-1:0]   count;
  logic [DIGITS-1:0]  blank_next;
  logic               zero_above;
`ifdef BIN2BCD_SIGNED_EN
  logic               neg_pend;
`endif

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (acc[gi*BCD_W +: BCD_W]),
      .corrected(acc_fixed[gi*BCD_W +: BCD_W])
    );
  end

  always_comb begin
`ifdef BIN2BCD_SIGNED_EN
    mag = value[BITS-1] ? -value : value;
`else
    mag = value;
`endif
  end

  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (acc[i*BCD_W +: BCD_W] == '0);
      blank_next[i] = zero_above;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The count==0 SHIFT cycle only latches the result, giving BITS+1 cycles to out_valid.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (count == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      operand  <= '0;
      count    <= '0;
      bcd      <= '0;
      blank    <= BLANK_RST;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend <= 1'b0;
      neg      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= '0;
            operand  <= mag;
            count    <= CNT_W'(BITS);
`ifdef BIN2BCD_SIGNED_EN
            neg_pend <= value[BITS-1];
`endif
          end
        end
        SHIFT: begin
          if (count != '0) begin
            {acc, operand} <= {acc_fixed[ACC_W-2:0], operand, 1'b0};
            count          <= count - 1'b1;
          end else begin
            bcd   <= acc;
            blank <= blank_next;
`ifdef BIN2BCD_SIGNED_EN
            neg   <= neg_pend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
